arf_sequencer: RTL and testbench

Sequencing controller and round-robin arbiter for the address register file (PC, SP, AR). It shares the file between four requesters: instruction fetch, stack push, stack pop and direct register load. For each granted request it issues the correct RegSel, FunSel, OutCSel and data-input sequence, and returns a one-cycle acknowledge when the addressed value is valid on the file's OutC. It also keeps a shadow stack-depth count so that overflow and underflow are flagged instead of corrupting SP.

---
 rtl/arf_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_arf_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arf_sequencer.sv
// Sequencer and round-robin arbiter for the PC/SP/AR address register file.
// Issues select/function sequences per request and tracks a shadow stack depth.
module arf_sequencer #(
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [3:0]                           req,
  input  logic [1:0]                           load_sel,
  input  logic [15:0]                          load_data,
  output logic [3:0]                           ack,
  output logic                                 err,
  output logic                                 busy,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
  output logic [2:0]                           arf_regsel,
  output logic [1:0]                           arf_funsel,
  output logic [1:0]                           arf_outcsel,
  output logic [1:0]                           arf_outdsel,
  output logic [31:0]                          arf_i
);

  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
  localparam logic [DepthW-1:0] DepthFull = DepthW'(STACK_DEPTH);

  typedef enum logic [3:0] {
    StIdle,
    StFSel,
    StFInc,
    StPDec,
    StPSel,
    StPAck,
    StQSel,
    StQInc,
    StLWr,
    StLAck,
    StErr
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [1:0]          r_last_grant;
  logic [1:0]          r_load_sel;
  logic [15:0]         r_load_data;
  logic [1:0]          r_outcsel;
  logic [DepthW-1:0]   r_depth;
  logic [DepthW-1:0]   w_depth_d;
  logic [1:0]          w_outcsel_d;
  logic                w_grant_vld;
  logic [1:0]          w_grant;
  logic                w_grant_now;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    logic [1:0] idx;
    w_grant_vld = 1'b0;
    w_grant     = r_last_grant;
    for (int i = 1; i <= 4; i++) begin
      idx = r_last_grant + 2'(i);
      if (!w_grant_vld && req[idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = idx;
      end
    end
  end

  assign w_grant_now = (r_state == StIdle) && w_grant_vld;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant_vld) begin
          unique case (w_grant)
            2'd0:    w_state_d = StFSel;
            2'd1:    w_state_d = (r_depth == DepthFull) ? StErr : StPDec;
            2'd2:    w_state_d = (r_depth == '0) ? StErr : StQSel;
            default: w_state_d = (load_sel == 2'b11) ? StErr : StLWr;
          endcase
        end
      end
      StFSel:  w_state_d = StFInc;
      StPDec:  w_state_d = StPSel;
      StPSel:  w_state_d = StPAck;
      StQSel:  w_state_d = StQInc;
      StLWr:   w_state_d = StLAck;
      StFInc,
      StPAck,
      StQInc,
      StLAck,
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    ack        = 4'b0000;
    err        = 1'b0;
    arf_regsel = 3'b000;
    arf_funsel = 2'b00;
    unique case (r_state)
      StFInc: begin
        ack        = 4'b0001;
        arf_regsel = 3'b100;
        arf_funsel = 2'b01;
      end
      StPDec: begin
        arf_regsel = 3'b010;
        arf_funsel = 2'b00;
      end
      StPAck: ack = 4'b0010;
      StQInc: begin
        ack        = 4'b0100;
        arf_regsel = 3'b010;
        arf_funsel = 2'b01;
      end
      StLWr: begin
        arf_funsel = 2'b10;
        unique case (r_load_sel)
          2'b00:   arf_regsel = 3'b100;
          2'b01:   arf_regsel = 3'b010;
          2'b10:   arf_regsel = 3'b001;
          default: arf_regsel = 3'b000;
        endcase
      end
      StLAck: ack = 4'b1000;
      StErr: begin
        ack = 4'b0001 << r_last_grant;
        err = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != StIdle);
  assign depth       = r_depth;
  assign arf_outcsel = r_outcsel;
  assign arf_outdsel = 2'b10;
  assign arf_i       = {16'h0000, r_load_data};

  // OutC select is loaded on entry so it is already valid during the *_SEL state.
  always_comb begin
    w_outcsel_d = r_outcsel;
    if (w_state_d == StFSel) begin
      w_outcsel_d = 2'b00;
    end else if ((w_state_d == StPSel) || (w_state_d == StQSel)) begin
      w_outcsel_d = 2'b01;
    end
  end

  always_comb begin
    w_depth_d = r_depth;
    if (r_state == StPDec) begin
      w_depth_d = r_depth + 1'b1;
    end else if (r_state == StQInc) begin
      w_depth_d = r_depth - 1'b1;
    end else if ((r_state == StLWr) && (r_load_sel == 2'b01)) begin
      w_depth_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 2'd3;
      r_load_sel   <= 2'b00;
      r_load_data  <= 16'h0000;
      r_outcsel    <= 2'b00;
      r_depth      <= '0;
    end else begin
      r_outcsel <= w_outcsel_d;
      r_depth   <= w_depth_d;
      if (w_grant_now) begin
        r_last_grant <= w_grant;
        if (w_grant == 2'd3) begin
          r_load_sel  <= load_sel;
          r_load_data <= load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: register-file model plus ack scoreboard.
module tb_arf_sequencer;

  localparam int unsigned StackDepth = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [1:0]  load_sel;
  logic [15:0] load_data;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic [4:0]  depth;
  logic [2:0]  arf_regsel;
  logic [1:0]  arf_funsel;
  logic [1:0]  arf_outcsel;
  logic [1:0]  arf_outdsel;
  logic [31:0] arf_i;

  arf_sequencer #(.STACK_DEPTH(StackDepth)) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .load_sel    (load_sel),
    .load_data   (load_data),
    .ack         (ack),
    .err         (err),
    .busy        (busy),
    .depth       (depth),
    .arf_regsel  (arf_regsel),
    .arf_funsel  (arf_funsel),
    .arf_outcsel (arf_outcsel),
    .arf_outdsel (arf_outdsel),
    .arf_i       (arf_i)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Register file model with registered OutC.
  logic [15:0] m_pc = 16'h0, m_sp = 16'h0, m_ar = 16'h0, m_outc = 16'h0;

  function automatic logic [15:0] fapply(input logic [15:0] v, input logic [1:0] fs,
                                         input logic [15:0] d);
    case (fs)
      2'b00:   return v - 16'd1;
      2'b01:   return v + 16'd1;
      2'b10:   return d;
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    case (arf_outcsel)
      2'b00:   m_outc <= m_pc;
      2'b01:   m_outc <= m_sp;
      default: m_outc <= m_ar;
    endcase
    if (arf_regsel[2]) m_pc <= fapply(m_pc, arf_funsel, arf_i[15:0]);
    if (arf_regsel[1]) m_sp <= fapply(m_sp, arf_funsel, arf_i[15:0]);
    if (arf_regsel[0]) m_ar <= fapply(m_ar, arf_funsel, arf_i[15:0]);
  end

  typedef struct {
    logic [3:0]  ack;
    logic        err;
    bit          chk_outc;
    logic [15:0] outc;
    logic [4:0]  depth;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic [2:0] rs_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack pulse is matched against the oldest expectation.
  exp_t mon_e;
  always @(negedge clock) begin
    if (reset_n && ack != 4'b0000) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=%b, expected none", ack);
      end else begin
        mon_e = sb.pop_front();
        check("ack", 64'(ack), 64'(mon_e.ack));
        check("err", 64'(err), 64'(mon_e.err));
        if (mon_e.chk_outc) check("outc", 64'(m_outc), 64'(mon_e.outc));
        check("depth_at_ack", 64'(depth), 64'(mon_e.depth));
        check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end else if (reset_n && err) begin
      n_checks++;
      n_fail++;
      $display("FAIL err_without_ack: got err=1, expected 0");
    end
  end

  task automatic run_op(input int id, input logic [1:0] sel, input logic [15:0] data,
                        input int lat, input bit exp_err, input bit chk_outc,
                        input logic [15:0] exp_outc, input logic [4:0] d_ack,
                        input logic [4:0] d_after);
    exp_t e;
    bit   got;
    @(negedge clock);
    e.ack      = 4'b0001 << id;
    e.err      = exp_err;
    e.chk_outc = chk_outc;
    e.outc     = exp_outc;
    e.depth    = d_ack;
    e.cyc      = cyc + lat;
    sb.push_back(e);
    load_sel  = sel;
    load_data = data;
    req[id]   = 1'b1;
    got       = 1'b0;
    rs_seen   = 3'b000;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      rs_seen = rs_seen | arf_regsel;
      if (ack[id]) got = 1'b1;
    end
    req[id] = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack for req %0d, expected one", id);
      sb.delete();
    end
    @(negedge clock);
    check("depth_after", 64'(depth), 64'(d_after));
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req     = 4'b0000;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  localparam logic [51:0] ResetVec = {4'b0, 1'b0, 1'b0, 5'd0, 3'b0, 2'b0, 2'b0, 2'b10, 32'h0};

  initial begin
    exp_t e;
    int   n;
    int   base;
    int   rr_cyc[8];
    reset_n   = 1'b0;
    req       = 4'b0000;
    load_sel  = 2'b00;
    load_data = 16'h0000;
    rr_cyc    = '{2, 6, 9, 12, 15, 19, 22, 25};
    #12;
    check("reset_outputs", 64'({ack, err, busy, depth, arf_regsel, arf_funsel, arf_outcsel,
                                arf_outdsel, arf_i}), 64'(ResetVec));
    @(negedge clock);
    reset_n = 1'b1;

    // Load PC then two post-increment fetches.
    run_op(3, 2'b00, 16'h0100, 2, 1'b0, 1'b0, 16'h0, 5'd0, 5'd0);
    check("pc_loaded", 64'(m_pc), 64'h0100);
    run_op(0, 2'b00, 16'h0, 2, 1'b0, 1'b1, 16'h0100, 5'd0, 5'd0);
    run_op(0, 2'b00, 16'h0, 2, 1'b0, 1'b1, 16'h0101, 5'd0, 5'd0);
    check("pc_final", 64'(m_pc), 64'h0102);

    // Stack push/pop round trip.
    run_op(3, 2'b01, 16'h00FF, 2, 1'b0, 1'b0, 16'h0, 5'd0, 5'd0);
    run_op(1, 2'b00, 16'h0, 3, 1'b0, 1'b1, 16'h00FE, 5'd1, 5'd1);
    run_op(1, 2'b00, 16'h0, 3, 1'b0, 1'b1, 16'h00FD, 5'd2, 5'd2);
    run_op(2, 2'b00, 16'h0, 2, 1'b0, 1'b1, 16'h00FD, 5'd2, 5'd1);
    run_op(2, 2'b00, 16'h0, 2, 1'b0, 1'b1, 16'h00FE, 5'd1, 5'd0);
    check("sp_restored", 64'(m_sp), 64'h00FF);

    // Underflow.
    run_op(2, 2'b00, 16'h0, 1, 1'b1, 1'b0, 16'h0, 5'd0, 5'd0);
    check("sp_after_underflow", 64'(m_sp), 64'h00FF);

    // Overflow on push STACK_DEPTH+1.
    for (int k = 1; k <= 16; k++) begin
      run_op(1, 2'b00, 16'h0, 3, 1'b0, 1'b1, 16'(16'h00FF - k), 5'(k), 5'(k));
    end
    run_op(1, 2'b00, 16'h0, 1, 1'b1, 1'b0, 16'h0, 5'd16, 5'd16);
    check("sp_after_overflow", 64'(m_sp), 64'h00EF);

    // Illegal load target.
    run_op(3, 2'b11, 16'hBEEF, 1, 1'b1, 1'b0, 16'h0, 5'd16, 5'd16);
    check("illegal_load_regsel", 64'(rs_seen), 64'h0);
    check("ar_untouched", 64'(m_ar), 64'h0);

    // All four requests held from reset: strict rotation.
    pulse_reset();
    @(negedge clock);
    base = cyc;
    for (int k = 0; k < 8; k++) begin
      e.ack      = 4'b0001 << (k % 4);
      e.err      = 1'b0;
      e.chk_outc = 1'b0;
      e.outc     = 16'h0;
      e.depth    = ((k % 4) == 1 || (k % 4) == 2) ? 5'd1 : 5'd0;
      e.cyc      = base + rr_cyc[k];
      sb.push_back(e);
    end
    load_sel  = 2'b10;
    load_data = 16'h1234;
    req       = 4'b1111;
    n         = 0;
    for (int k = 0; k < 60 && n < 8; k++) begin
      @(negedge clock);
      if (ack != 4'b0000) n++;
    end
    req = 4'b0000;
    check("rr_ack_count", 64'(n), 64'd8);
    if (n != 8) sb.delete();
    @(negedge clock);
    check("ar_loaded", 64'(m_ar), 64'h1234);
    check("rr_depth", 64'(depth), 64'd0);

    // Reset asserted during P_SEL aborts with no ack.
    @(negedge clock);
    req[1] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("psel_state", 64'({busy, depth, arf_outcsel, ack}), 64'({1'b1, 5'd1, 2'b01, 4'b0}));
    reset_n = 1'b0;
    req     = 4'b0000;
    #1;
    check("reset_mid_op", 64'({ack, err, busy, depth, arf_regsel, arf_funsel, arf_outcsel,
                               arf_outdsel, arf_i}), 64'(ResetVec));
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_after_reset", 64'(busy), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
